tt_seq: RTL

TT_SEQ -- requirements
Module: tt_seq

---
 rtl/tt_seq_pkg.sv | 24 ++
 rtl/tt_dwell_cnt.sv | 23 ++
 rtl/tt_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tt_seq_pkg.sv
// Shared types and helpers for the truth-table sequencer: FSM state encoding,
// vector geometry and the index-to-pin mapping.
package tt_seq_pkg;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Result is packed as {a,b,c,d}; with msb_first clear, a takes idx[0].
  function automatic logic [3:0] idx_to_vec(input logic [IDX_W-1:0] i,
                                            input logic             msb_first);
    logic [3:0] v;
    if (msb_first) v = i;
    else           v = {i[0], i[1], i[2], i[3]};
    return v;
  endfunction

endpackage

// File: rtl/tt_dwell_cnt.sv
// Dwell timer for the sequencer: 8-bit counter with clear/enable and a
// terminal flag raised when the count reaches HOLD_CYC-1.
module tt_dwell_cnt #(
  parameter int unsigned HOLD_CYC = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 8'd1;
  end

  assign o_term = (r_cnt == 8'(HOLD_CYC - 1));

endmodule

// File: rtl/tt_seq.sv
// Truth-table sequencer: sweeps all 16 input vectors onto a,b,c,d and captures
// the downstream response y into tt. Optional expected-table checking is
// enabled by defining TT_SEQ_CHECK_EN.
module tt_seq
  import tt_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYC  = 10,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               y,
`ifdef TT_SEQ_CHECK_EN
  input  logic [NUM_VEC-1:0] exp_tt,
  output logic               mismatch,
  output logic [IDX_W-1:0]   fail_idx,
`endif
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] tt,
  output logic [IDX_W-1:0]   idx
);

  localparam logic LP_MSB = (MSB_FIRST != 0);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [NUM_VEC-1:0] r_tt;
  logic [3:0]         r_vec;

  logic w_term;
  logic w_accept;
  logic w_capture;
  logic w_last;
  logic w_cnt_clr;
  logic w_cnt_en;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_last    = (r_idx == IDX_W'(NUM_VEC - 1));

  tt_dwell_cnt #(
    .HOLD_CYC (HOLD_CYC)
  ) u_dwell (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_term  (w_term)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE,
      ST_DONE:   if (start) w_next = ST_DRIVE;
      ST_DRIVE:  if (w_term) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = w_last ? ST_DONE : ST_DRIVE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_cnt_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE:   w_accept = start;
      ST_DONE:   begin
        w_accept = start;
        done     = 1'b1;
      end
      ST_DRIVE:  begin
        w_cnt_en = !w_term;
        busy     = 1'b1;
      end
      ST_SAMPLE: begin
        w_capture = 1'b1;
        busy      = 1'b1;
      end
      default:   ;
    endcase
    w_cnt_clr = w_accept || (w_capture && !w_last);
  end

  // Vector, index and table advance together so a,b,c,d always reflect idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_tt  <= '0;
      r_vec <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_tt  <= '0;
      r_vec <= idx_to_vec('0, LP_MSB);
    end else if (w_capture) begin
      r_tt[r_idx] <= y;
      if (!w_last) begin
        r_idx <= w_idx_inc;
        r_vec <= idx_to_vec(w_idx_inc, LP_MSB);
      end
    end
  end

`ifdef TT_SEQ_CHECK_EN
  logic [NUM_VEC-1:0] r_exp_tt;
  logic               r_mismatch;
  logic [IDX_W-1:0]   r_fail_idx;

  // Only the first disagreeing vector is recorded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exp_tt   <= '0;
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_accept) begin
      r_exp_tt   <= exp_tt;
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_capture && !r_mismatch && (y != r_exp_tt[r_idx])) begin
      r_mismatch <= 1'b1;
      r_fail_idx <= r_idx;
    end
  end

  assign mismatch = r_mismatch;
  assign fail_idx = r_fail_idx;
`endif

  assign {a, b, c, d} = r_vec;
  assign tt           = r_tt;
  assign idx          = r_idx;

endmodule
